// File: rtl/memory_port_arbiter_if.sv
// Request/grant/done bundle between the core-side requesters, the arbiter
// and the single-port memory.
interface memory_port_arbiter_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic        busy;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_q,
        input  gnt, done, rdata, busy, mem_address, mem_data, mem_wren
    );

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_q,
        output gnt, done, rdata, busy, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between fetch, data and loader requesters:
// fixed priority data > fetch > loader, with a starvation guard for the loader.
module memory_port_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 8
) (
    input logic                  clock,
    input logic                  reset,
    memory_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [1:0] WAIT_LAST  = 2'(READ_LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic [1:0]  wait_cnt, wait_nxt;
    logic [2:0]  owner, owner_nxt;
    logic [2:0]  win;
    logic [2:0]  gnt_nxt, done_nxt;
    logic [15:0] addr_nxt, wdata_nxt, rdata_nxt;
    logic        wren_nxt;

    // A loader that has lost STARVE_LIMIT times jumps ahead of everyone.
    always_comb begin
        win = 3'b000;
        if (bus.ldr_req && (starve_cnt >= STARVE_LIM)) win = 3'b100;
        else if (bus.data_req)                         win = 3'b010;
        else if (bus.fetch_req)                        win = 3'b001;
        else if (bus.ldr_req)                          win = 3'b100;
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = 3'b000;
        done_nxt   = 3'b000;
        wren_nxt   = 1'b0;
        addr_nxt   = bus.mem_address;
        wdata_nxt  = bus.mem_data;
        rdata_nxt  = bus.rdata;
        owner_nxt  = owner;
        wait_nxt   = wait_cnt;
        starve_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (bus.ldr_req && !win[2])
                    starve_nxt = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
                else
                    starve_nxt = 4'd0;
                if (win != 3'b000) begin
                    state_nxt = ISSUE;
                    gnt_nxt   = win;
                    owner_nxt = win;
                    case (win)
                        3'b010: begin
                            addr_nxt  = bus.data_addr;
                            wdata_nxt = bus.data_wdata;
                            wren_nxt  = bus.data_we;
                        end
                        3'b100: begin
                            addr_nxt  = bus.ldr_addr;
                            wdata_nxt = bus.ldr_wdata;
                            wren_nxt  = bus.ldr_we;
                        end
                        default: addr_nxt = bus.fetch_addr;
                    endcase
                end
            end
            ISSUE: begin
                wait_nxt = 2'd0;
                if (bus.mem_wren) begin
                    done_nxt  = owner;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    rdata_nxt = bus.mem_q;
                    done_nxt  = owner;
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            starve_cnt      <= 4'd0;
            wait_cnt        <= 2'd0;
            owner           <= 3'b000;
            bus.gnt         <= 3'b000;
            bus.done        <= 3'b000;
            bus.mem_wren    <= 1'b0;
            bus.mem_address <= 16'h0000;
            bus.mem_data    <= 16'h0000;
            bus.rdata       <= 16'h0000;
        end else begin
            state           <= state_nxt;
            starve_cnt      <= starve_nxt;
            wait_cnt        <= wait_nxt;
            owner           <= owner_nxt;
            bus.gnt         <= gnt_nxt;
            bus.done        <= done_nxt;
            bus.mem_wren    <= wren_nxt;
            bus.mem_address <= addr_nxt;
            bus.mem_data    <= wdata_nxt;
            bus.rdata       <= rdata_nxt;
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: two instances (read latency 1 and 3) with
// behavioural negedge memories and a per-instance done/rdata scoreboard.
module tb_memory_port_arbiter;
    typedef struct {
        logic [2:0]  who;
        logic [15:0] rdata;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   gd, gf, gx;

    exp_t        sb1[$];
    exp_t        sb3[$];
    logic [15:0] m1 [logic [15:0]];
    logic [15:0] exp_rd1 = 16'h0000;
    logic [15:0] exp_rd3 = 16'h0000;

    memory_port_arbiter_if b1();
    memory_port_arbiter_if b3();

    memory_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(3)) dut1 (
        .clock(clock), .reset(reset), .bus(b1));
    memory_port_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(8)) dut3 (
        .clock(clock), .reset(reset), .bus(b3));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memories clocked on the falling edge; dut3's read data takes 3 cycles.
    logic [15:0] mem1 [0:1023];
    logic [15:0] mem3 [0:1023];
    logic [15:0] q1;
    logic [15:0] p3 [0:2];
    always @(negedge clock) begin
        if (b1.mem_wren) mem1[b1.mem_address[9:0]] <= b1.mem_data;
        q1 <= mem1[b1.mem_address[9:0]];
        if (b3.mem_wren) mem3[b3.mem_address[9:0]] <= b3.mem_data;
        p3[0] <= mem3[b3.mem_address[9:0]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.mem_q = q1;
    assign b3.mem_q = p3[2];

    always @(negedge clock) begin
        exp_t e;
        if (b1.done != 3'b000) begin
            tests++;
            if (sb1.size() == 0) begin
                fails++;
                $display("FAIL sb1_unexpected_done: done=%b required none", b1.done);
            end else begin
                e = sb1.pop_front();
                if (b1.done !== e.who || b1.rdata !== e.rdata) begin
                    fails++;
                    $display("FAIL sb1_done: done=%b rdata=%h required done=%b rdata=%h",
                             b1.done, b1.rdata, e.who, e.rdata);
                end
            end
        end
        if (b3.done != 3'b000) begin
            tests++;
            if (sb3.size() == 0) begin
                fails++;
                $display("FAIL sb3_unexpected_done: done=%b required none", b3.done);
            end else begin
                e = sb3.pop_front();
                if (b3.done !== e.who || b3.rdata !== e.rdata) begin
                    fails++;
                    $display("FAIL sb3_done: done=%b rdata=%h required done=%b rdata=%h",
                             b3.done, b3.rdata, e.who, e.rdata);
                end
            end
        end
    end

    task automatic drop_reqs1();
        b1.fetch_req = 1'b0;
        b1.data_req  = 1'b0;
        b1.ldr_req   = 1'b0;
    endtask

    // Raise one request on dut1, wait for its grant, check the issue cycle and
    // push the expected completion.
    task automatic req1(input int who, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int gcyc);
        exp_t e;
        bit   got = 1'b0;
        gcyc = -1;
        case (who)
            0: begin b1.fetch_addr = addr; b1.fetch_req = 1'b1; end
            1: begin b1.data_we = we; b1.data_addr = addr; b1.data_wdata = wdata; b1.data_req = 1'b1; end
            default: begin b1.ldr_we = we; b1.ldr_addr = addr; b1.ldr_wdata = wdata; b1.ldr_req = 1'b1; end
        endcase
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (b1.gnt[who]) got = 1'b1;
        end
        case (who)
            0:       b1.fetch_req = 1'b0;
            1:       b1.data_req  = 1'b0;
            default: b1.ldr_req   = 1'b0;
        endcase
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL gnt_timeout: requester %0d got no grant, required one within 40 cycles", who);
        end else begin
            gcyc = cyc;
            e.who = 3'(1 << who);
            tests++;
            if (b1.gnt !== e.who || b1.mem_address !== addr || b1.mem_wren !== we ||
                (we && b1.mem_data !== wdata)) begin
                fails++;
                $display("FAIL issue_%0d: gnt=%b addr=%h wren=%b data=%h required gnt=%b addr=%h wren=%b data=%h",
                         who, b1.gnt, b1.mem_address, b1.mem_wren, b1.mem_data, e.who, addr, we, wdata);
            end
            if (we) begin
                m1[addr] = wdata;
                e.rdata  = exp_rd1;
            end else begin
                e.rdata  = m1[addr];
                exp_rd1  = e.rdata;
            end
            sb1.push_back(e);
            if (we) begin
                @(negedge clock);
                tests++;
                if (b1.mem_wren !== 1'b0 || b1.gnt !== 3'b000 || b1.done !== e.who) begin
                    fails++;
                    $display("FAIL write_done_%0d: wren=%b gnt=%b done=%b required wren=0 gnt=000 done=%b",
                             who, b1.mem_wren, b1.gnt, b1.done, e.who);
                end
            end
        end
    endtask

    task automatic drain1();
        for (int i = 0; i < 40 && (sb1.size() != 0 || b1.busy); i++) @(negedge clock);
        tests++;
        if (sb1.size() != 0 || b1.busy !== 1'b0) begin
            fails++;
            $display("FAIL drain1: pending=%0d busy=%b required pending=0 busy=0", sb1.size(), b1.busy);
        end
    endtask

    task automatic wait_gnt3(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (b3.gnt[2]) got = 1'b1;
        end
        b3.ldr_req = 1'b0;
        tests++;
        if (!got || b3.gnt !== 3'b100) begin
            fails++;
            $display("FAIL gnt3_ldr: gnt=%b required 100", b3.gnt);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        tests++;
        if (b1.gnt !== 3'b000 || b1.done !== 3'b000 || b1.busy !== 1'b0 ||
            b1.mem_wren !== 1'b0 || b1.rdata !== 16'h0000) begin
            fails++;
            $display("FAIL reset_dut1: gnt=%b done=%b busy=%b wren=%b rdata=%h required all 0",
                     b1.gnt, b1.done, b1.busy, b1.mem_wren, b1.rdata);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        tests++;
        if (b1.gnt !== 3'b000 || b1.busy !== 1'b0 || b3.busy !== 1'b0 ||
            b3.rdata !== 16'h0000 || dut1.starve_cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_idle: gnt=%b busy1=%b busy3=%b rdata3=%h starve=%0d required 0",
                     b1.gnt, b1.busy, b3.busy, b3.rdata, dut1.starve_cnt);
        end
    endtask

    task automatic test_fetch_read();
        req1(2, 1'b1, 16'h0010, 16'hABCD, gx);
        drain1();
        req1(0, 1'b0, 16'h0010, 16'h0000, gx);
        @(negedge clock);
        tests++;
        if (b1.gnt !== 3'b000 || b1.done !== 3'b000 || b1.busy !== 1'b1 || b1.mem_address !== 16'h0010) begin
            fails++;
            $display("FAIL fetch_wait: gnt=%b done=%b busy=%b addr=%h required 000 000 1 0010",
                     b1.gnt, b1.done, b1.busy, b1.mem_address);
        end
        @(negedge clock);
        tests++;
        if (b1.done !== 3'b001 || b1.rdata !== 16'hABCD) begin
            fails++;
            $display("FAIL fetch_done: done=%b rdata=%h required 001 abcd", b1.done, b1.rdata);
        end
        drain1();
    endtask

    task automatic test_priority();
        fork
            req1(1, 1'b1, 16'h0200, 16'h1234, gd);
            req1(0, 1'b0, 16'h0200, 16'h0000, gf);
        join
        tests++;
        if (gd < 0 || gf - gd != 2) begin
            fails++;
            $display("FAIL priority_order: data grant cycle %0d fetch grant cycle %0d required fetch = data + 2", gd, gf);
        end
        drain1();
    endtask

    task automatic test_starvation();
        exp_t e;
        int   arb = 0;
        int   won = -1;
        b1.ldr_we = 1'b1;  b1.ldr_addr = 16'h0301;  b1.ldr_wdata = 16'h2222;
        b1.data_we = 1'b1; b1.data_addr = 16'h0300; b1.data_wdata = 16'h1111;
        b1.fetch_addr = 16'h0010;
        b1.ldr_req = 1'b1; b1.data_req = 1'b1; b1.fetch_req = 1'b1;
        for (int i = 0; i < 30 && won < 0; i++) begin
            @(negedge clock);
            if (b1.gnt != 3'b000) begin
                arb++;
                e.who = b1.gnt;
                if (b1.gnt[1]) begin
                    m1[16'h0300] = 16'h1111; e.rdata = exp_rd1;
                end else if (b1.gnt[0]) begin
                    e.rdata = m1[16'h0010]; exp_rd1 = e.rdata;
                end else begin
                    m1[16'h0301] = 16'h2222; e.rdata = exp_rd1;
                    won = arb;
                    drop_reqs1();
                    tests++;
                    if (dut1.starve_cnt !== 4'd0 || b1.mem_address !== 16'h0301 || b1.mem_wren !== 1'b1) begin
                        fails++;
                        $display("FAIL starve_grant: starve=%0d addr=%h wren=%b required 0 0301 1",
                                 dut1.starve_cnt, b1.mem_address, b1.mem_wren);
                    end
                end
                sb1.push_back(e);
            end
        end
        drop_reqs1();
        tests++;
        if (won != 4) begin
            fails++;
            $display("FAIL starve_limit: loader granted on arbitration %0d required 4", won);
        end
        drain1();
    endtask

    task automatic test_reset_mid_wait();
        bit got = 1'b0;
        b1.data_we = 1'b0; b1.data_addr = 16'h0300; b1.data_req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (b1.gnt[1]) got = 1'b1;
        end
        b1.data_req = 1'b0;
        @(negedge clock);
        tests++;
        if (!got || b1.busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_wait_setup: granted=%b busy=%b required 1 1", got, b1.busy);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (b1.busy !== 1'b0 || b1.done !== 3'b000 || b1.gnt !== 3'b000 || b1.mem_wren !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: busy=%b done=%b gnt=%b wren=%b required all 0",
                     b1.busy, b1.done, b1.gnt, b1.mem_wren);
        end
        @(negedge clock);
        reset = 1'b0;
        exp_rd1 = 16'h0000;
        exp_rd3 = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tests++;
            if (b1.done !== 3'b000) begin
                fails++;
                $display("FAIL post_reset_done: done=%b required 000", b1.done);
            end
        end
        req1(0, 1'b0, 16'h0300, 16'h0000, gx);
        drain1();
    endtask

    task automatic test_latency3();
        exp_t e;
        bit   got;
        b3.ldr_we = 1'b1; b3.ldr_addr = 16'h0040; b3.ldr_wdata = 16'h5EED; b3.ldr_req = 1'b1;
        wait_gnt3(got);
        e.who = 3'b100; e.rdata = exp_rd3;
        sb3.push_back(e);
        @(negedge clock);
        b3.ldr_we = 1'b0; b3.ldr_req = 1'b1;
        wait_gnt3(got);
        e.rdata = 16'h5EED;
        sb3.push_back(e);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            tests++;
            if (b3.busy !== 1'b1 || b3.done !== 3'b000 || b3.rdata !== exp_rd3) begin
                fails++;
                $display("FAIL lat3_wait%0d: busy=%b done=%b rdata=%h required 1 000 %h",
                         k, b3.busy, b3.done, b3.rdata, exp_rd3);
            end
        end
        @(negedge clock);
        tests++;
        if (b3.done !== 3'b100 || b3.rdata !== 16'h5EED || b3.busy !== 1'b0) begin
            fails++;
            $display("FAIL lat3_done: done=%b rdata=%h busy=%b required 100 5eed 0", b3.done, b3.rdata, b3.busy);
        end
        exp_rd3 = 16'h5EED;
        @(negedge clock);
        tests++;
        if (b3.done !== 3'b000 || sb3.size() != 0) begin
            fails++;
            $display("FAIL lat3_after: done=%b pending=%0d required 000 0", b3.done, sb3.size());
        end
    endtask

    initial begin
        b1.fetch_req = 1'b0; b1.fetch_addr = '0; b1.data_req = 1'b0; b1.data_we = 1'b0;
        b1.data_addr = '0; b1.data_wdata = '0; b1.ldr_req = 1'b0; b1.ldr_we = 1'b0;
        b1.ldr_addr = '0; b1.ldr_wdata = '0;
        b3.fetch_req = 1'b0; b3.fetch_addr = '0; b3.data_req = 1'b0; b3.data_we = 1'b0;
        b3.data_addr = '0; b3.data_wdata = '0; b3.ldr_req = 1'b0; b3.ldr_we = 1'b0;
        b3.ldr_addr = '0; b3.ldr_wdata = '0;
        test_reset();
        test_fetch_read();
        test_priority();
        test_starvation();
        test_reset_mid_wait();
        test_latency3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Sequences and shares the single-port 16-bit `Memory` between three requesters: instruction fetch (phase 1), data load/store (phase 4), and an external loader/debug port used to fill program memory. It sits between the phase-driven CPU core and the `Memory` instance. It replaces direct phase-decoded address muxing with a request/grant/done handshake, so that the core stalls while the loader owns the port. Arbitration is fixed priority with a starvation guard for the loader.

## Interface
- `READ_LATENCY`, 1: cycles from the memory address cycle until `mem_q` is valid (1..4).
- `STARVE_LIMIT`, 8: number of lost arbitrations after which a waiting loader is forced to win (1..15).

Clock and reset: one clock; reset is asynchronous and active-high.

- `clock` in 1: rising-edge clock for the block; `Memory` is clocked by `!clock` at top level.
- `reset` in 1: asynchronous, active-high.
- `fetch_req` in 1: fetch read request.
- `fetch_addr` in 16: fetch address (PC).
- `data_req` in 1: load/store request.
- `data_we` in 1: 1 = store, 0 = load.
- `data_addr` in 16: data address (DR).
- `data_wdata` in 16: store data.
- `ldr_req` in 1: loader request.
- `ldr_we` in 1: loader write enable.
- `ldr_addr` in 16: loader address.
- `ldr_wdata` in 16: loader write data.
- `gnt` out 3: one-cycle grant pulse; bit0 fetch, bit1 data, bit2 loader.
- `done` out 3: one-cycle completion pulse, same bit order.
- `rdata` out 16: read data, valid while the matching `done` bit is high.
- `busy` out 1: high in ISSUE and WAIT.
- `mem_address` out 16: to `Memory.address`.
- `mem_data` out 16: to `Memory.data`.
- `mem_wren` out 1: to `Memory.wren`.
- `mem_q` in 16: from `Memory.q`.

## Operation
- States: IDLE, ISSUE, WAIT.
- Reset state: IDLE, with all outputs and the starvation counter at 0.
- **IDLE:** when any req is high, pick a winner and move to ISSUE.
  - If the loader counter is at or above STARVE_LIMIT and `ldr_req` is high, the loader wins.
  - Otherwise the priority is data > fetch > loader.
- **Entering ISSUE:** register the winner's addr, wdata and we into `mem_address`, `mem_data` and `mem_wren`, and register the winner's `gnt` bit.
  - Fetch always reads, so `mem_wren` = 0 for a fetch grant.
- **ISSUE** lasts exactly 1 cycle. At its end, `gnt` and `mem_wren` go to 0.
  - Write: return to IDLE and pulse `done`. `rdata` is unchanged.
  - Read: go to WAIT.
- **WAIT** lasts READ_LATENCY cycles. On the final edge, capture `rdata` ← `mem_q`, pulse `done` and return to IDLE.
- `mem_address` holds its value through WAIT. In IDLE it holds the last value; it is not cleared.
- Requesters keep addr/we/wdata stable from req until `gnt`. They must drop req on the edge ending the `gnt` cycle. A req still high in IDLE is a new request.
- All reqs are ignored in ISSUE and WAIT; they are only sampled in IDLE.
- Starvation counter (4 bits), updated only on IDLE arbitration edges:
  - Increment (saturating at 15) when `ldr_req` is high and the loader loses.
  - Clear when the loader is granted or `ldr_req` is low.
- Reset mid-operation: asynchronous return to IDLE.
  - `mem_wren`, `gnt` and `done` drop immediately.
  - The in-flight access produces no `done`. A write may or may not have reached memory; software must not rely on it.

## Timing
- Let E0 be the edge where IDLE samples the winning req.
- Write: `gnt` and `mem_wren` are high in cycle E0→E1. `done` is high in cycle E1→E2.
- Read: `gnt` is high in E0→E1, WAIT runs from E1 to E(1+READ_LATENCY), and `done` plus `rdata` are valid in the following cycle.
  - With READ_LATENCY=1, `done` comes 3 cycles after req is first seen.
- The `done` cycle is IDLE, so a new request is sampled at its ending edge. Back-to-back throughput is 2 cycles per write and 2+READ_LATENCY cycles per read.
- At most one `gnt` bit and at most one `done` bit is high in any cycle.

## Test plan
- Reset with all reqs = 0 → `gnt`=0, `done`=0, `busy`=0, `mem_wren`=0, `rdata`=0; stays in IDLE.
- Fetch read of 0x0010 with `mem_q`=0xABCD (READ_LATENCY=1) → `gnt`=001 for 1 cycle, `mem_address`=0x0010, `done`=001 two cycles later with `rdata`=0xABCD.
- `data_req` and `fetch_req` high together, data store of 0x1234 to 0x0200 → data is granted first with `mem_wren`=1 for exactly 1 cycle and `done`=010 next cycle; fetch is granted on the following arbitration.
- Loader writes held continuously while data/fetch re-request every IDLE cycle, with STARVE_LIMIT=3 → loader is granted on the 4th arbitration at the latest, and the counter then reads 0.
- Reset asserted mid-WAIT of a data load → `busy` and `done` go to 0 immediately, no `done` pulse follows, and the next fetch after reset completes normally.
- READ_LATENCY=3 with a loader read → WAIT lasts 3 cycles, `rdata` is captured on the 3rd WAIT edge, and `done`=100 is high for 1 cycle.
